// File: rtl/compare_track_if.sv
// Sample and result bundle for the compare_track debounce stage.
// The master drives comparator flags and clr; the slave publishes the tracked relation.
interface compare_track_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             xgy;
  logic             xsy;
  logic             xey;
  logic             clr;
  logic [1:0]       state_o;
  logic             change;
  logic             err;
  logic [CNT_W-1:0] cnt_gt;
  logic [CNT_W-1:0] cnt_sy;
  logic [CNT_W-1:0] cnt_eq;

  modport master (
    output in_valid, xgy, xsy, xey, clr,
    input  state_o, change, err, cnt_gt, cnt_sy, cnt_eq
  );

  modport slave (
    input  in_valid, xgy, xsy, xey, clr,
    output state_o, change, err, cnt_gt, cnt_sy, cnt_eq
  );
endinterface

// File: rtl/compare_track.sv
// Debounce/tracking stage for magnitude-comparator flags; commits a relation after DEB_LEN
// identical legal samples. Per-relation counters are built only with COMPARE_TRACK_CNT_EN defined.
module compare_track #(
  parameter int DEB_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  compare_track_if.slave  bus
);

  localparam int RUN_W = $clog2(DEB_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEB_LEN);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_LESS    = 2'b01,
    ST_EQUAL   = 2'b10,
    ST_GREATER = 2'b11
  } rel_e;

  rel_e             state_q, state_d;
  rel_e             cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             change_q, change_d;
  logic             err_q, err_d;

  logic             legal;
  rel_e             cls;

  // Exactly one flag high is a legal sample; UNKNOWN doubles as "no candidate".
  always_comb begin
    legal = bus.in_valid && $onehot({bus.xgy, bus.xsy, bus.xey});
    if (bus.xsy)      cls = ST_LESS;
    else if (bus.xey) cls = ST_EQUAL;
    else              cls = ST_GREATER;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    state_d  = state_q;
    cand_d   = cand_q;
    run_d    = run_q;
    change_d = 1'b0;
    err_d    = 1'b0;

    if (bus.in_valid && !legal) begin
      err_d  = 1'b1;
      cand_d = ST_UNKNOWN;
      run_d  = '0;
    end else if (legal) begin
      if (cls == cand_q) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end else begin
        cand_d = cls;
        run_d  = RUN_W'(1);
      end
      // A saturated run on the already-committed relation must not pulse again.
      if (run_d == RUN_MAX && cand_d != state_q) begin
        state_d  = cand_d;
        change_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_UNKNOWN;
      cand_q   <= ST_UNKNOWN;
      run_q    <= '0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      change_q <= change_d;
      err_q    <= err_d;
    end
  end

  assign bus.state_o = state_q;
  assign bus.change  = change_q;
  assign bus.err     = err_q;

`ifdef COMPARE_TRACK_CNT_EN
  logic [CNT_W-1:0] cnt_gt_q, cnt_gt_d;
  logic [CNT_W-1:0] cnt_sy_q, cnt_sy_d;
  logic [CNT_W-1:0] cnt_eq_q, cnt_eq_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // clr wins over a simultaneous increment.
  always_comb begin
    cnt_gt_d = cnt_gt_q;
    cnt_sy_d = cnt_sy_q;
    cnt_eq_d = cnt_eq_q;
    if (bus.clr) begin
      cnt_gt_d = '0;
      cnt_sy_d = '0;
      cnt_eq_d = '0;
    end else if (legal) begin
      case (cls)
        ST_GREATER: cnt_gt_d = sat_inc(cnt_gt_q);
        ST_LESS:    cnt_sy_d = sat_inc(cnt_sy_q);
        default:    cnt_eq_d = sat_inc(cnt_eq_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gt_q <= '0;
      cnt_sy_q <= '0;
      cnt_eq_q <= '0;
    end else begin
      cnt_gt_q <= cnt_gt_d;
      cnt_sy_q <= cnt_sy_d;
      cnt_eq_q <= cnt_eq_d;
    end
  end

  assign bus.cnt_gt = cnt_gt_q;
  assign bus.cnt_sy = cnt_sy_q;
  assign bus.cnt_eq = cnt_eq_q;
`else
  logic unused_clr;
  assign unused_clr = bus.clr;
  assign bus.cnt_gt = '0;
  assign bus.cnt_sy = '0;
  assign bus.cnt_eq = '0;
`endif

endmodule

// File: tb/tb_compare_track.sv
// Scoreboard bench for compare_track: a DEB_LEN=4 and a DEB_LEN=1 instance share the stimulus,
// and a reference model pushes expected outputs that are popped one cycle later.
module tb_compare_track;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef COMPARE_TRACK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  compare_track_if #(.CNT_W(CNT_W)) bus4 ();
  compare_track_if #(.CNT_W(CNT_W)) bus1 ();

  compare_track #(.DEB_LEN(4), .CNT_W(CNT_W)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  compare_track #(.DEB_LEN(1), .CNT_W(CNT_W)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [1:0] state;
    logic [1:0] cand;
    int         run;
    bit         change;
    bit         err;
    int         cgt;
    int         csy;
    int         ceq;
  } model_t;

  typedef struct {
    model_t m4;
    model_t m1;
  } exp_t;

  model_t m4, m1;
  exp_t   sb_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_chg4  = 0;
  int     n_chg1  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.state = 2'b00; m.cand = 2'b00; m.run = 0; m.change = 0; m.err = 0;
    m.cgt = 0; m.csy = 0; m.ceq = 0;
    return m;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Reference behaviour written straight from the relation/debounce rules.
  function automatic model_t step(input model_t m, input bit v, input bit g, input bit s,
                                  input bit e, input bit c, input int deb);
    model_t     n;
    int         ones;
    logic [1:0] cls;
    n = m;
    n.change = 0;
    n.err    = 0;
    ones = int'(g) + int'(s) + int'(e);
    if (v) begin
      if (ones != 1) begin
        n.err  = 1;
        n.cand = 2'b00;
        n.run  = 0;
      end else begin
        cls = s ? 2'b01 : (e ? 2'b10 : 2'b11);
        if (cls == m.cand) n.run = (m.run + 1 > deb) ? deb : m.run + 1;
        else begin
          n.cand = cls;
          n.run  = 1;
        end
        if (n.run == deb && n.cand != m.state) begin
          n.state  = n.cand;
          n.change = 1;
        end
        if (CNT_EN) begin
          if (cls == 2'b11) n.cgt = sat(m.cgt);
          else if (cls == 2'b01) n.csy = sat(m.csy);
          else n.ceq = sat(m.ceq);
        end
      end
    end
    if (CNT_EN && c) begin
      n.cgt = 0; n.csy = 0; n.ceq = 0;
    end
    return n;
  endfunction

  task automatic cmp(input string p, input model_t m, input logic [1:0] st, input logic ch,
                     input logic er, input logic [CNT_W-1:0] g, input logic [CNT_W-1:0] s,
                     input logic [CNT_W-1:0] q);
    check({p, "_state"},  32'(st), 32'(m.state));
    check({p, "_change"}, 32'(ch), 32'(m.change));
    check({p, "_err"},    32'(er), 32'(m.err));
    check({p, "_cnt_gt"}, 32'(g),  32'(m.cgt));
    check({p, "_cnt_sy"}, 32'(s),  32'(m.csy));
    check({p, "_cnt_eq"}, 32'(q),  32'(m.ceq));
  endtask

  // One clock of stimulus: drive, push the model's prediction, then pop and compare after the edge.
  task automatic cyc(input bit v, input bit g, input bit s, input bit e, input bit c);
    exp_t x;
    bus4.in_valid = v; bus4.xgy = g; bus4.xsy = s; bus4.xey = e; bus4.clr = c;
    bus1.in_valid = v; bus1.xgy = g; bus1.xsy = s; bus1.xey = e; bus1.clr = c;
    m4 = step(m4, v, g, s, e, c, 4);
    m1 = step(m1, v, g, s, e, c, 1);
    x.m4 = m4;
    x.m1 = m1;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      cmp("d4", x.m4, bus4.state_o, bus4.change, bus4.err, bus4.cnt_gt, bus4.cnt_sy, bus4.cnt_eq);
      cmp("d1", x.m1, bus1.state_o, bus1.change, bus1.err, bus1.cnt_gt, bus1.cnt_sy, bus1.cnt_eq);
    end
    if (bus4.change) n_chg4++;
    if (bus1.change) n_chg1++;
  endtask

  task automatic gt(input bit c = 0);  cyc(1, 1, 0, 0, c); endtask
  task automatic lt(input bit c = 0);  cyc(1, 0, 1, 0, c); endtask
  task automatic eq(input bit c = 0);  cyc(1, 0, 0, 1, c); endtask
  task automatic idle(input bit c = 0); cyc(0, 0, 0, 0, c); endtask

  task automatic check_all_zero(input string p);
    check({p, "_d4_state"},  32'(bus4.state_o), 32'd0);
    check({p, "_d4_change"}, 32'(bus4.change),  32'd0);
    check({p, "_d4_err"},    32'(bus4.err),     32'd0);
    check({p, "_d4_cnt_gt"}, 32'(bus4.cnt_gt),  32'd0);
    check({p, "_d4_cnt_sy"}, 32'(bus4.cnt_sy),  32'd0);
    check({p, "_d4_cnt_eq"}, 32'(bus4.cnt_eq),  32'd0);
    check({p, "_d1_state"},  32'(bus1.state_o), 32'd0);
  endtask

  initial begin
    int         c0;
    int         cnt_before;
    bit         rv, rg, rs, re, rc;
    logic [1:0] sticky;

    rst_n = 1'b0;
    bus4.in_valid = 0; bus4.xgy = 0; bus4.xsy = 0; bus4.xey = 0; bus4.clr = 0;
    bus1.in_valid = 0; bus1.xgy = 0; bus1.xsy = 0; bus1.xey = 0; bus1.clr = 0;
    m4 = model_reset();
    m1 = model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a GREATER run discards it.
    repeat (3) gt();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    m4 = model_reset();
    m1 = model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    c0 = n_chg4;
    repeat (3) gt();
    check("rst_no_early_change", 32'(n_chg4 - c0), 32'd0);
    gt();
    check("rst_commit_gt", 32'(bus4.state_o), 32'd3);
    check("rst_commit_pulse", 32'(bus4.change), 32'd1);

    // Saturated run on the committed relation: no re-pulse, counter advances by 10.
    cnt_before = int'(bus4.cnt_gt);
    c0 = n_chg4;
    repeat (10) gt();
    check("no_repulse", 32'(n_chg4 - c0), 32'd0);
    check("cnt_gt_delta", 32'(int'(bus4.cnt_gt) - cnt_before), CNT_EN ? 32'd10 : 32'd0);

    // Interrupted run, then a 5-cycle gap inside the final run.
    c0 = n_chg4;
    repeat (3) lt();
    eq();
    lt();
    repeat (5) idle();
    lt();
    lt();
    check("deb_before_commit", 32'(bus4.state_o), 32'd3);
    lt();
    check("deb_commit_less", 32'(bus4.state_o), 32'd1);
    check("deb_one_pulse", 32'(n_chg4 - c0), 32'd1);

    // Illegal double flag breaks an EQUAL run; all-zero flags are illegal too.
    repeat (3) eq();
    cyc(1, 1, 1, 0, 0);
    check("illegal_two_err", 32'(bus4.err), 32'd1);
    repeat (3) eq();
    check("illegal_run_reset", 32'(bus4.state_o), 32'd1);
    eq();
    check("illegal_then_eq", 32'(bus4.state_o), 32'd2);
    cyc(1, 0, 0, 0, 0);
    check("illegal_zero_err", 32'(bus4.err), 32'd1);
    cyc(1, 1, 1, 1, 0);
    idle();
    check("err_one_cycle", 32'(bus4.err), 32'd0);

    // Counter saturation and clear priority.
    idle(1);
    repeat (20) eq();
    check("cnt_eq_sat", 32'(bus4.cnt_eq), CNT_EN ? 32'(CMAX) : 32'd0);
    eq(1);
    check("clr_beats_inc", 32'(bus4.cnt_eq), 32'd0);
    check("clr_keeps_state", 32'(bus4.state_o), 32'd2);

    // DEB_LEN=1 follows every differing legal sample immediately.
    c0 = n_chg1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) gt(); else lt();
      check("d1_toggle", 32'(bus1.state_o), (i % 2 == 0) ? 32'd3 : 32'd1);
    end
    check("d1_pulse_count", 32'(n_chg1 - c0), 32'd8);

    // Constrained-random soak with sticky classes so runs do complete.
    sticky = 2'b11;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) sticky = 2'($urandom_range(1, 3));
      rg = (sticky == 2'b11);
      rs = (sticky == 2'b01);
      re = (sticky == 2'b10);
      if ($urandom_range(0, 11) == 0) begin
        rg = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
      end
      rc = ($urandom_range(0, 31) == 0);
      cyc(rv, rg, rs, re, rc);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
